// File: rtl/mem_pkg.sv
// Shared definitions for the mem_be_pipe storage block: FSM encodings,
// legal read-latency range and the byte-lane helper.
package mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int byte_lanes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Response shift pipeline carrying {r_valid, err, r_data} with a synchronous
// flush. The data field only advances alongside a valid read, so r_data holds.
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_err,
  input  logic [WIDTH-1:0] in_data,
  output logic             r_valid,
  output logic             err,
  output logic [WIDTH-1:0] r_data
);

  // Out-of-range latencies are clamped to the nearest legal depth.
  localparam int LAT = (RD_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : RD_LATENCY;

  typedef struct packed {
    logic             v;
    logic             e;
    logic [WIDTH-1:0] d;
  } stage_t;

  stage_t st_q [LAT];
  stage_t st_d [LAT];

  always_comb begin
    st_d[0].v = in_valid;
    st_d[0].e = in_err;
    st_d[0].d = in_valid ? in_data : st_q[0].d;
    for (int i = 1; i < LAT; i++) begin
      st_d[i].v = st_q[i-1].v;
      st_d[i].e = st_q[i-1].e;
      st_d[i].d = st_q[i-1].v ? st_q[i-1].d : st_q[i].d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        st_q[i] <= '0;
      end
    end else begin
      st_q <= st_d;
    end
  end

  assign r_valid = st_q[LAT-1].v;
  assign err     = st_q[LAT-1].e;
  assign r_data  = st_q[LAT-1].d;

endmodule

// File: rtl/mem_be_pipe.sv
// Single-port memory with valid/ready requests, byte enables, pipelined reads,
// out-of-range error strobes and a hardware clear sweep (INIT state).
module mem_be_pipe
  import mem_pkg::*;
#(
  parameter int              WIDTH      = 16,
  parameter int              DEPTH      = 16,
  parameter int              ADDR_WIDTH = $clog2(DEPTH),
  parameter int              RD_LATENCY = 1,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_rd,
  input  logic [WIDTH-1:0]      w_data,
  input  logic [WIDTH/8-1:0]    be,
  input  logic                  valid,
  input  logic                  clr,
  output logic                  ready,
  output logic [WIDTH-1:0]      r_data,
  output logic                  r_valid,
  output logic                  err,
  output logic                  init_done
);

  // Handshake: a request transfers on any rising edge where valid && ready.
  // ready is a pure function of state and never looks at valid.

  localparam int LANES = byte_lanes(WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]    CNT_MAX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             sweep_we;

  logic             accept;
  logic             in_range;
  logic             wr_acc;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] rd_word;

  assign ready     = (state_q == ST_IDLE);
  assign init_done = (state_q == ST_IDLE);
  assign accept    = valid && ready;
  assign in_range  = ({1'b0, addr} < DEPTH_A);
  assign idx       = addr[IDX_W-1:0];
  assign wr_acc    = accept && wr_rd && in_range;
  assign rd_word   = in_range ? mem[idx] : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + IDX_W'(1);
        if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage is intentionally not reset so backdoor loads survive until a sweep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_we) begin
        mem[cnt_q] <= INIT_VAL;
      end else if (wr_acc) begin
        for (int k = 0; k < LANES; k++) begin
          if (be[k]) begin
            mem[idx][k*8 +: 8] <= w_data[k*8 +: 8];
          end
        end
      end
    end
  end

  mem_rd_pipe #(
    .WIDTH      (WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept && !wr_rd),
    .in_err   (accept && !in_range),
    .in_data  (rd_word),
    .r_valid  (r_valid),
    .err      (err),
    .r_data   (r_data)
  );

endmodule

// File: tb/tb_mem_be_pipe.sv
// Self-checking bench for mem_be_pipe: default instance (a_), RD_LATENCY=2
// instance (b_) and DEPTH=12 instance (c_) sharing one clock and reset.
module tb_mem_be_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m0 [16];
  logic [15:0] m2 [12];

  logic [3:0]  a_addr;  logic a_wr_rd, a_valid, a_clr;
  logic [15:0] a_wdata; logic [1:0] a_be;
  logic        a_ready, a_rvalid, a_err, a_init;
  logic [15:0] a_rdata;

  logic [3:0]  b_addr;  logic b_wr_rd, b_valid, b_clr;
  logic [15:0] b_wdata; logic [1:0] b_be;
  logic        b_ready, b_rvalid, b_err, b_init;
  logic [15:0] b_rdata;

  logic [3:0]  c_addr;  logic c_wr_rd, c_valid, c_clr;
  logic [15:0] c_wdata; logic [1:0] c_be;
  logic        c_ready, c_rvalid, c_err, c_init;
  logic [15:0] c_rdata;

  mem_be_pipe #(.WIDTH(16), .DEPTH(16), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .addr(a_addr), .wr_rd(a_wr_rd), .w_data(a_wdata),
    .be(a_be), .valid(a_valid), .clr(a_clr), .ready(a_ready), .r_data(a_rdata),
    .r_valid(a_rvalid), .err(a_err), .init_done(a_init));

  mem_be_pipe #(.WIDTH(16), .DEPTH(16), .RD_LATENCY(2)) dut_lat2 (
    .clk(clk), .rst(rst), .addr(b_addr), .wr_rd(b_wr_rd), .w_data(b_wdata),
    .be(b_be), .valid(b_valid), .clr(b_clr), .ready(b_ready), .r_data(b_rdata),
    .r_valid(b_rvalid), .err(b_err), .init_done(b_init));

  mem_be_pipe #(.WIDTH(16), .DEPTH(12), .ADDR_WIDTH(4), .RD_LATENCY(1)) dut_d12 (
    .clk(clk), .rst(rst), .addr(c_addr), .wr_rd(c_wr_rd), .w_data(c_wdata),
    .be(c_be), .valid(c_valid), .clr(c_clr), .ready(c_ready), .r_data(c_rdata),
    .r_valid(c_rvalid), .err(c_err), .init_done(c_init));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_valid = 0; a_clr = 0; a_wr_rd = 0; a_addr = 0; a_wdata = 0; a_be = 0;
    b_valid = 0; b_clr = 0; b_wr_rd = 0; b_addr = 0; b_wdata = 0; b_be = 0;
    c_valid = 0; c_clr = 0; c_wr_rd = 0; c_addr = 0; c_wdata = 0; c_be = 0;
  endtask

  // Drives one request on the default instance and updates the model/queue.
  task automatic a_drive(input logic w, input logic [3:0] a,
                         input logic [15:0] d, input logic [1:0] b);
    a_valid = 1; a_wr_rd = w; a_addr = a; a_wdata = d; a_be = b;
    if (w) begin
      for (int k = 0; k < 2; k++)
        if (b[k]) m0[a][k*8 +: 8] = d[k*8 +: 8];
    end else begin
      exp_q.push_back(m0[a]);
    end
  endtask

  task automatic c_drive(input logic w, input logic [3:0] a,
                         input logic [15:0] d, input logic [1:0] b);
    c_valid = 1; c_wr_rd = w; c_addr = a; c_wdata = d; c_be = b;
    if (w && a < 12) begin
      for (int k = 0; k < 2; k++)
        if (b[k]) m2[a][k*8 +: 8] = d[k*8 +: 8];
    end
  endtask

  task automatic test_reset();
    int ka, kb, kc;
    logic [15:0] e;
    rst = 1;
    idle_all();
    for (int i = 0; i < 16; i++) m0[i] = 16'h0;
    for (int i = 0; i < 12; i++) m2[i] = 16'h0;
    step(); step();
    n_cmp++;
    if ({a_ready, a_rvalid, a_err, a_init} !== 4'b0 || a_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy/rv/err/done=%b r_data=%h want 0000/0000",
               {a_ready, a_rvalid, a_err, a_init}, a_rdata);
    end
    rst = 0;
    ka = 0; kb = 0; kc = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (a_ready && ka == 0) ka = i;
      if (b_ready && kb == 0) kb = i;
      if (c_ready && kc == 0) kc = i;
    end
    n_cmp++;
    if (ka != 16) begin n_fail++; $display("FAIL sweep_len_a: ready after %0d want 16", ka); end
    n_cmp++;
    if (kb != 16) begin n_fail++; $display("FAIL sweep_len_b: ready after %0d want 16", kb); end
    n_cmp++;
    if (kc != 12) begin n_fail++; $display("FAIL sweep_len_c: ready after %0d want 12", kc); end
    n_cmp++;
    if (a_init !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b want 1", a_init); end
    a_drive(0, 4'd5, 16'h0, 2'b00);
    step();
    a_valid = 0;
    e = exp_q.pop_front();
    n_cmp++;
    if (a_rvalid !== 1'b1 || a_rdata !== e) begin
      n_fail++;
      $display("FAIL reset_read5: r_valid=%b r_data=%h want 1/%h", a_rvalid, a_rdata, e);
    end
  endtask

  task automatic test_full_write();
    logic [15:0] e;
    a_drive(1, 4'd3, 16'h4148, 2'b11);
    step();
    n_cmp++;
    if (a_rvalid !== 1'b0 || a_err !== 1'b0) begin
      n_fail++;
      $display("FAIL write_no_strobe: r_valid=%b err=%b want 0/0", a_rvalid, a_err);
    end
    a_drive(0, 4'd3, 16'h0, 2'b00);
    step();
    a_valid = 0;
    e = exp_q.pop_front();
    n_cmp++;
    if (a_rvalid !== 1'b1 || a_rdata !== e) begin
      n_fail++;
      $display("FAIL full_write: r_valid=%b r_data=%h want 1/%h", a_rvalid, a_rdata, e);
    end
    b_valid = 1; b_wr_rd = 1; b_addr = 4'd3; b_wdata = 16'h4148; b_be = 2'b11;
    step();
    b_wr_rd = 0;
    step();
    b_valid = 0;
    n_cmp++;
    if (b_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL lat2_early: r_valid=%b want 0 one cycle after accept", b_rvalid);
    end
    step();
    n_cmp++;
    if (b_rvalid !== 1'b1 || b_rdata !== 16'h4148) begin
      n_fail++;
      $display("FAIL lat2_read: r_valid=%b r_data=%h want 1/4148", b_rvalid, b_rdata);
    end
    step();
    n_cmp++;
    if (b_rvalid !== 1'b0 || b_rdata !== 16'h4148) begin
      n_fail++;
      $display("FAIL lat2_hold: r_valid=%b r_data=%h want 0/4148", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_byte_en();
    logic [15:0] e;
    a_drive(1, 4'd2, 16'hFFFF, 2'b11); step();
    a_drive(1, 4'd2, 16'h1234, 2'b01); step();
    a_drive(0, 4'd2, 16'h0, 2'b00);    step();
    a_valid = 0;
    e = exp_q.pop_front();
    n_cmp++;
    if (a_rvalid !== 1'b1 || a_rdata !== e || e !== 16'hFF34) begin
      n_fail++;
      $display("FAIL byte_en: r_valid=%b r_data=%h want 1/ff34 (model %h)", a_rvalid, a_rdata, e);
    end
    step();
    n_cmp++;
    if (a_rvalid !== 1'b0 || a_rdata !== 16'hFF34) begin
      n_fail++;
      $display("FAIL rdata_hold: r_valid=%b r_data=%h want 0/ff34", a_rvalid, a_rdata);
    end
    a_drive(1, 4'd2, 16'h0000, 2'b00); step();
    a_drive(0, 4'd2, 16'h0, 2'b00);    step();
    a_valid = 0;
    e = exp_q.pop_front();
    n_cmp++;
    if (a_rvalid !== 1'b1 || a_rdata !== e) begin
      n_fail++;
      $display("FAIL be_zero: r_valid=%b r_data=%h want 1/%h", a_rvalid, a_rdata, e);
    end
  endtask

  task automatic test_order_stream();
    logic [15:0] e;
    int strobes;
    a_drive(1, 4'd7, 16'hBEEF, 2'b11); step();
    a_drive(0, 4'd7, 16'h0, 2'b00);    step();
    a_valid = 0;
    e = exp_q.pop_front();
    n_cmp++;
    if (a_rvalid !== 1'b1 || a_rdata !== e) begin
      n_fail++;
      $display("FAIL wr_then_rd: r_valid=%b r_data=%h want 1/%h", a_rvalid, a_rdata, e);
    end
    for (int i = 8; i < 16; i++) begin
      a_drive(1, 4'(i), 16'($urandom_range(0, 16'hFFFF)), 2'($urandom_range(1, 3)));
      step();
    end
    strobes = 0;
    for (int i = 0; i < 16; i++) begin
      a_drive(0, 4'(i), 16'h0, 2'b00);
      step();
      if (a_rvalid === 1'b1) strobes++;
      e = exp_q.pop_front();
      n_cmp++;
      if (a_rvalid !== 1'b1 || a_rdata !== e) begin
        n_fail++;
        $display("FAIL stream[%0d]: r_valid=%b r_data=%h want 1/%h", i, a_rvalid, a_rdata, e);
      end
    end
    a_valid = 0;
    step();
    n_cmp++;
    if (strobes != 16 || a_rvalid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_count: strobes=%0d tail_rv=%b q=%0d want 16/0/0",
               strobes, a_rvalid, exp_q.size());
    end
  endtask

  task automatic test_out_of_range();
    c_drive(1, 4'd2, 16'h1111, 2'b11); step();
    c_drive(0, 4'd2, 16'h0, 2'b00);    step();
    n_cmp++;
    if (c_rvalid !== 1'b1 || c_err !== 1'b0 || c_rdata !== 16'h1111) begin
      n_fail++;
      $display("FAIL oor_setup: rv=%b err=%b r_data=%h want 1/0/1111", c_rvalid, c_err, c_rdata);
    end
    c_drive(1, 4'd14, 16'hAAAA, 2'b11); step();
    c_valid = 0;
    n_cmp++;
    if (c_err !== 1'b1 || c_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_write: err=%b r_valid=%b want 1/0", c_err, c_rvalid);
    end
    step();
    n_cmp++;
    if (c_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse: err=%b want 0", c_err); end
    c_drive(0, 4'd13, 16'h0, 2'b00); step();
    n_cmp++;
    if (c_rvalid !== 1'b1 || c_err !== 1'b1 || c_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL oor_read13: rv=%b err=%b r_data=%h want 1/1/0000", c_rvalid, c_err, c_rdata);
    end
    c_drive(0, 4'd12, 16'h0, 2'b00); step();
    n_cmp++;
    if (c_rvalid !== 1'b1 || c_err !== 1'b1 || c_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL oor_read12: rv=%b err=%b r_data=%h want 1/1/0000", c_rvalid, c_err, c_rdata);
    end
    for (int i = 0; i < 12; i++) begin
      c_drive(0, 4'(i), 16'h0, 2'b00);
      step();
      n_cmp++;
      if (c_rvalid !== 1'b1 || c_err !== 1'b0 || c_rdata !== m2[i]) begin
        n_fail++;
        $display("FAIL oor_unchanged[%0d]: rv=%b err=%b r_data=%h want 1/0/%h",
                 i, c_rvalid, c_err, c_rdata, m2[i]);
      end
    end
    c_valid = 0;
    step();
  endtask

  task automatic test_clear();
    logic [15:0] e;
    int lows;
    a_drive(1, 4'd3, 16'h5555, 2'b11); step();
    a_drive(0, 4'd3, 16'h0, 2'b00);
    a_clr = 1;
    step();
    a_valid = 0; a_clr = 0;
    e = exp_q.pop_front();
    n_cmp++;
    if (a_rvalid !== 1'b1 || a_rdata !== e || a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_inflight: rv=%b r_data=%h rdy=%b want 1/%h/0", a_rvalid, a_rdata, a_ready, e);
    end
    for (int i = 0; i < 16; i++) m0[i] = 16'h0;
    lows = 1;
    for (int g = 0; g < 40 && !a_ready; g++) begin
      step();
      if (!a_ready) lows++;
    end
    n_cmp++;
    if (lows != 16) begin n_fail++; $display("FAIL clr_len: ready low %0d cycles want 16", lows); end
    a_drive(0, 4'd3, 16'h0, 2'b00); step();
    a_valid = 0;
    e = exp_q.pop_front();
    n_cmp++;
    if (a_rvalid !== 1'b1 || a_rdata !== e) begin
      n_fail++;
      $display("FAIL clr_read3: r_valid=%b r_data=%h want 1/%h", a_rvalid, a_rdata, e);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] e;
    int k;
    a_drive(1, 4'd9, 16'hC3A5, 2'b11); step();
    for (int i = 0; i < 5; i++) begin
      a_drive(0, 4'(i + 6), 16'h0, 2'b00);
      if (i == 4) rst = 1;
      step();
      if (i < 4) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (a_rvalid !== 1'b1 || a_rdata !== e) begin
          n_fail++;
          $display("FAIL pre_rst[%0d]: r_valid=%b r_data=%h want 1/%h", i, a_rvalid, a_rdata, e);
        end
      end
    end
    a_valid = 0;
    exp_q.delete();
    n_cmp++;
    if (a_rvalid !== 1'b0 || a_ready !== 1'b0 || a_err !== 1'b0 || a_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_rst: rv=%b rdy=%b err=%b r_data=%h want 0/0/0/0000",
               a_rvalid, a_ready, a_err, a_rdata);
    end
    rst = 0;
    for (int i = 0; i < 16; i++) m0[i] = 16'h0;
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      step();
      if (a_ready) k = i;
    end
    n_cmp++;
    if (k != 16) begin n_fail++; $display("FAIL rerun_sweep: ready after %0d want 16", k); end
    a_drive(0, 4'd9, 16'h0, 2'b00); step();
    a_valid = 0;
    e = exp_q.pop_front();
    n_cmp++;
    if (a_rvalid !== 1'b1 || a_rdata !== e) begin
      n_fail++;
      $display("FAIL rst_read9: r_valid=%b r_data=%h want 1/%h", a_rvalid, a_rdata, e);
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_full_write();
    test_byte_en();
    test_order_stream();
    test_out_of_range();
    test_clear();
    test_mid_reset();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
